// File: rtl/fbuf_stream_writer.sv
// rtl/fbuf_stream_writer.sv - AXI4-Stream video frame writer into a BRAM framebuffer
// Optional double buffering: a finished frame is handed to the display at the next blanking edge.
module fbuf_stream_writer #(
  parameter int FRAME_WIDTH     = 320,
  parameter int FRAME_HEIGHT    = 240,
  parameter int FBUF_ADDR_WIDTH = 18,
  parameter int PIXEL_WIDTH     = 24,
  parameter int DOUBLE_BUFFER   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PIXEL_WIDTH-1:0]     s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  input  logic                       disp_eof,
  output logic                       wr_en,
  output logic [FBUF_ADDR_WIDTH-1:0] wr_addr,
  output logic [PIXEL_WIDTH-1:0]     wr_data,
  output logic                       rd_bank,
  output logic                       frame_done,
  output logic                       err_sof,
  output logic                       err_eol
);
  localparam logic [FBUF_ADDR_WIDTH-1:0] L_ONE   = FBUF_ADDR_WIDTH'(1);
  localparam logic [FBUF_ADDR_WIDTH-1:0] L_LINE  = FBUF_ADDR_WIDTH'(FRAME_WIDTH);
  localparam logic [FBUF_ADDR_WIDTH-1:0] L_FRAME = FBUF_ADDR_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT);
  localparam logic [12:0]                L_X_LAST = 13'(FRAME_WIDTH - 1);
  localparam logic [12:0]                L_Y_LAST = 13'(FRAME_HEIGHT - 1);
  localparam bit                         L_DB     = (DOUBLE_BUFFER != 0);

  typedef enum logic [1:0] {S_WAIT_SOF, S_WRITE, S_HOLD} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [12:0]                r_x;
  logic [12:0]                r_y;
  logic [FBUF_ADDR_WIDTH-1:0] r_addr;
  logic [FBUF_ADDR_WIDTH-1:0] r_line;
  logic                       r_wr_bank;
  logic                       r_rd_bank;
  logic                       r_eof_d1;
  logic                       r_tready;
  logic                       r_wr_en;
  logic [FBUF_ADDR_WIDTH-1:0] r_wr_addr;
  logic [PIXEL_WIDTH-1:0]     r_wr_data;
  logic                       r_frame_done;
  logic                       r_err_sof;
  logic                       r_err_eol;

  logic                       w_accept;
  logic                       w_write;
  logic                       w_swap;
  logic [FBUF_ADDR_WIDTH-1:0] w_base;
  logic [12:0]                w_x_cur;
  logic [12:0]                w_y_cur;
  logic [FBUF_ADDR_WIDTH-1:0] w_addr_cur;
  logic [FBUF_ADDR_WIDTH-1:0] w_line_cur;
  logic                       w_x_end;
  logic                       w_y_end;
  logic                       w_frame_end;
  logic [12:0]                w_x_nxt;
  logic [12:0]                w_y_nxt;
  logic [FBUF_ADDR_WIDTH-1:0] w_addr_nxt;
  logic [FBUF_ADDR_WIDTH-1:0] w_line_nxt;
  logic                       w_tready_nxt;
  logic                       w_frame_done;
  logic                       w_err_sof;
  logic                       w_err_eol;

  assign w_accept = s_axis_tvalid && r_tready;
  assign w_write  = w_accept && ((r_state == S_WRITE) ||
                                 ((r_state == S_WAIT_SOF) && s_axis_tuser));
  assign w_swap   = L_DB && (r_state == S_HOLD) && disp_eof && !r_eof_d1;
  assign w_base   = r_wr_bank ? L_FRAME : '0;

  // A tuser beat is always pixel (0,0) of the current bank, whatever the counters say.
  assign w_x_cur     = s_axis_tuser ? 13'd0  : r_x;
  assign w_y_cur     = s_axis_tuser ? 13'd0  : r_y;
  assign w_addr_cur  = s_axis_tuser ? w_base : r_addr;
  assign w_line_cur  = s_axis_tuser ? w_base : r_line;
  assign w_x_end     = (w_x_cur == L_X_LAST);
  assign w_y_end     = (w_y_cur == L_Y_LAST);
  assign w_frame_end = w_x_end && w_y_end;

  always_comb begin
    w_x_nxt    = w_x_cur + 13'd1;
    w_y_nxt    = w_y_cur;
    w_addr_nxt = w_addr_cur + L_ONE;
    w_line_nxt = w_line_cur;
    if (w_frame_end) begin
      w_x_nxt    = '0;
      w_y_nxt    = '0;
      w_addr_nxt = w_base;
      w_line_nxt = w_base;
    end else if (w_x_end || s_axis_tlast) begin
      // An early tlast on the last line wraps back to line 0 rather than leaving the frame.
      w_x_nxt = '0;
      if (w_y_end) begin
        w_y_nxt    = '0;
        w_line_nxt = w_base;
      end else begin
        w_y_nxt    = w_y_cur + 13'd1;
        w_line_nxt = w_line_cur + L_LINE;
      end
      w_addr_nxt = w_line_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_WAIT_SOF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_SOF: begin
        if (w_write) begin
          if (w_frame_end) w_state_nxt = L_DB ? S_HOLD : S_WAIT_SOF;
          else             w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_write && w_frame_end) w_state_nxt = L_DB ? S_HOLD : S_WAIT_SOF;
      end
      S_HOLD: begin
        if (w_swap) w_state_nxt = S_WAIT_SOF;
      end
      default: w_state_nxt = S_WAIT_SOF;
    endcase
  end

  always_comb begin
    w_tready_nxt = (w_state_nxt != S_HOLD);
    w_frame_done = w_write && w_frame_end;
    w_err_sof    = w_write && (r_state == S_WRITE) && s_axis_tuser;
    w_err_eol    = w_write && (w_x_end != s_axis_tlast);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_line       <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_eof_d1     <= 1'b0;
      r_tready     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_err_sof    <= 1'b0;
      r_err_eol    <= 1'b0;
    end else begin
      r_eof_d1     <= disp_eof;
      r_tready     <= w_tready_nxt;
      r_wr_en      <= w_write;
      r_frame_done <= w_frame_done;
      r_err_sof    <= w_err_sof;
      r_err_eol    <= w_err_eol;
      if (w_write) begin
        r_wr_addr <= w_addr_cur;
        r_wr_data <= s_axis_tdata;
        r_x       <= w_x_nxt;
        r_y       <= w_y_nxt;
        r_addr    <= w_addr_nxt;
        r_line    <= w_line_nxt;
      end
      if (w_swap) begin
        r_rd_bank <= r_wr_bank;
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign rd_bank       = r_rd_bank;
  assign frame_done    = r_frame_done;
  assign err_sof       = r_err_sof;
  assign err_eol       = r_err_eol;
endmodule
